// File: rtl/video_sync_decoder.sv
// Receive-side sync decoder: flywheel hcount/vcount recovered from an active-low
// hsync/vsync pair, with a four-state lock tracker and timing-violation pulses.
module video_sync_decoder #(
  parameter int H_TOTAL      = 400,
  parameter int H_VISIBLE    = 320,
  parameter int H_SYNC_START = 328,
  parameter int H_SYNC_END   = 376,
  parameter int V_TOTAL      = 525,
  parameter int V_VISIBLE    = 480,
  parameter int V_SYNC_START = 490,
  parameter int LOCK_LINES   = 4
) (
  input  logic       clk_12_5875,
  input  logic       rst,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       h_locked,
  output logic       locked,
  output logic       visible,
  output logic       writable,
  output logic       frame_start,
  output logic       h_err,
  output logic       v_err
);
  localparam logic [9:0] HT1    = 10'(H_TOTAL - 1);
  localparam logic [9:0] HVIS   = 10'(H_VISIBLE);
  localparam logic [9:0] HSS    = 10'(H_SYNC_START);
  localparam logic [9:0] HSE    = 10'(H_SYNC_END);
  localparam logic [9:0] VT1    = 10'(V_TOTAL - 1);
  localparam logic [9:0] VVIS   = 10'(V_VISIBLE);
  localparam logic [9:0] VSS    = 10'(V_SYNC_START);
  localparam logic [2:0] LOCK_N = 3'(LOCK_LINES);

  typedef enum logic [1:0] {S_UNLOCKED, S_H_LOCK, S_V_ALIGN, S_LOCKED} state_t;

  state_t     r_state, w_state_n;
  logic       r_hs_prev, r_vs_prev;
  logic [9:0] r_hcount, r_vcount;
  logic [2:0] r_good_lines, w_good_n;
  logic       r_h_locked, r_locked, r_visible, r_writable, r_frame_start, r_h_err, r_v_err;

  logic       w_hs_fall, w_hs_rise, w_vs_fall, w_line_end, w_v_slot, w_lock_n;
  logic       w_h_err, w_v_err;
  logic [9:0] w_h_pred, w_v_pred, w_h_nxt, w_v_nxt;

  assign w_hs_fall  = r_hs_prev & ~hsync;
  assign w_hs_rise  = ~r_hs_prev & hsync;
  assign w_vs_fall  = r_vs_prev & ~vsync;
  assign w_line_end = (r_hcount == HT1);
  assign w_h_pred   = w_line_end ? 10'd0 : r_hcount + 10'd1;
  assign w_v_pred   = !w_line_end ? r_vcount : ((r_vcount == VT1) ? 10'd0 : r_vcount + 10'd1);
  assign w_h_nxt    = w_hs_fall ? HSS : w_h_pred;
  assign w_v_nxt    = w_vs_fall ? VSS : w_v_pred;
  // The one cycle per frame where a vsync fall must (and may only) arrive.
  assign w_v_slot   = (w_v_pred == VSS) && (w_h_pred == 10'd0);

  assign w_h_err = (r_state != S_UNLOCKED) &&
                   ((w_hs_fall && (w_h_pred != HSS)) ||
                    (!w_hs_fall && (w_h_pred == HSS)) ||
                    (w_hs_rise && (w_h_pred != HSE)));
  assign w_v_err = (r_state == S_LOCKED) && (w_vs_fall != w_v_slot);

  always_comb begin
    w_good_n = r_good_lines;
    if (w_hs_fall)
      w_good_n = (w_h_pred != HSS) ? 3'd0 :
                 (r_good_lines == 3'd7) ? 3'd7 : r_good_lines + 3'd1;
    if (w_h_err) w_good_n = 3'd0;
  end

  // h-error dominates so a simultaneous h/v violation lands in UNLOCKED.
  always_comb begin
    w_state_n = r_state;
    if (w_h_err) w_state_n = S_UNLOCKED;
    else begin
      case (r_state)
        S_UNLOCKED: if (w_good_n >= LOCK_N) w_state_n = S_H_LOCK;
        S_H_LOCK:   if (w_vs_fall) w_state_n = S_V_ALIGN;
        S_V_ALIGN:  if (w_vs_fall && w_v_slot) w_state_n = S_LOCKED;
        S_LOCKED:   if (w_v_err) w_state_n = S_H_LOCK;
        default:    w_state_n = S_UNLOCKED;
      endcase
    end
  end

  assign w_lock_n = (w_state_n == S_LOCKED);

  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      r_state       <= S_UNLOCKED;
      r_hs_prev     <= 1'b1;
      r_vs_prev     <= 1'b1;
      r_hcount      <= 10'd0;
      r_vcount      <= 10'd0;
      r_good_lines  <= 3'd0;
      r_h_locked    <= 1'b0;
      r_locked      <= 1'b0;
      r_visible     <= 1'b0;
      r_writable    <= 1'b0;
      r_frame_start <= 1'b0;
      r_h_err       <= 1'b0;
      r_v_err       <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_hs_prev     <= hsync;
      r_vs_prev     <= vsync;
      r_hcount      <= w_h_nxt;
      r_vcount      <= w_v_nxt;
      r_good_lines  <= w_good_n;
      r_h_locked    <= (w_state_n != S_UNLOCKED);
      r_locked      <= w_lock_n;
      r_visible     <= w_lock_n && (w_h_nxt < HVIS) && (w_v_nxt < VVIS);
      r_writable    <= w_lock_n && (w_v_nxt >= VVIS);
      r_frame_start <= w_lock_n && (r_vcount == VT1) && (w_v_nxt == 10'd0) && (w_h_nxt == 10'd0);
      r_h_err       <= w_h_err;
      r_v_err       <= w_v_err;
    end
  end

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign h_locked    = r_h_locked;
  assign locked      = r_locked;
  assign visible     = r_visible;
  assign writable    = r_writable;
  assign frame_start = r_frame_start;
  assign h_err       = r_h_err;
  assign v_err       = r_v_err;
endmodule

// File: tb/tb_video_sync_decoder.sv
// Bench for video_sync_decoder: a scaled-down sync source with injectable faults,
// event positions predicted from the lock/flywheel rules.
module tb_video_sync_decoder;
  localparam int H = 48, HV = 36, HSS = 38, HSE = 44;
  localparam int V = 24, VV = 18, VSS = 20, LL = 4;

  logic       clk = 1'b0;
  logic       rst, hsync, vsync;
  logic [9:0] hcount, vcount;
  logic       h_locked, locked, visible, writable, frame_start, h_err, v_err;

  int total = 0, bad = 0;
  int src_h = 0, src_v = 0, src_f = 0;
  int lag_h = 0, lag_v = 0, lag_f = 0;
  bit run = 0;
  int kind = 0, pert_f = -1, pert_l = -1;
  int n_herr = 0, n_verr = 0;

  always #5 clk = ~clk;

  video_sync_decoder #(
    .H_TOTAL(H), .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
    .V_TOTAL(V), .V_VISIBLE(VV), .V_SYNC_START(VSS), .LOCK_LINES(LL)
  ) dut (
    .clk_12_5875(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .hcount(hcount), .vcount(vcount), .h_locked(h_locked), .locked(locked),
    .visible(visible), .writable(writable), .frame_start(frame_start),
    .h_err(h_err), .v_err(v_err)
  );

  function automatic int pos(input int f, input int v, input int h);
    return (f * V + v) * H + h;
  endfunction

  // kind: 1 short line, 2 missing hsync pulse, 3 narrow hsync pulse, 4 late vsync
  task automatic drive_src();
    bit hit, in_pulse;
    int he, vs0;
    hit = (src_f == pert_f) && (src_v == pert_l);
    he = (kind == 3 && hit) ? HSE - 1 : HSE;
    in_pulse = (src_h >= HSS) && (src_h < he) && !(kind == 2 && hit);
    vs0 = (kind == 4 && src_f == pert_f) ? VSS + 1 : VSS;
    hsync = !in_pulse;
    vsync = !(src_v >= vs0 && src_v < vs0 + 2);
  endtask

  task automatic tick();
    int last;
    @(posedge clk); #1;
    lag_h = src_h; lag_v = src_v; lag_f = src_f;
    if (h_err) n_herr++;
    if (v_err) n_verr++;
    if (run) begin
      last = (kind == 1 && src_f == pert_f && src_v == pert_l) ? H - 2 : H - 1;
      if (src_h == last) begin
        src_h = 0;
        if (src_v == V - 1) begin src_v = 0; src_f++; end
        else src_v++;
      end else src_h++;
    end
    drive_src();
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 0; src_h = 0; src_v = 0; src_f = 0; kind = 0;
    drive_src();
    tick(); tick();
    total++;
    if (hcount !== 10'd0) begin bad++; $display("FAIL reset_hcount: got %0d expected 0", hcount); end
    total++;
    if (vcount !== 10'd0) begin bad++; $display("FAIL reset_vcount: got %0d expected 0", vcount); end
    total++;
    if ({h_locked, locked, visible, writable, frame_start, h_err, v_err} !== 7'd0) begin
      bad++; $display("FAIL reset_flags: got %b expected 0000000",
        {h_locked, locked, visible, writable, frame_start, h_err, v_err});
    end
  endtask

  task automatic test_clean_lock();
    int hl_pos, lk_pos, herr0, verr0;
    bit trk_ok;
    hl_pos = -1; lk_pos = -1; trk_ok = 1;
    herr0 = n_herr; verr0 = n_verr;
    rst = 1'b0; run = 1;
    for (int i = 0; i < 5 * V * H && lag_f < 4; i++) begin
      tick();
      if (h_locked && hl_pos < 0) hl_pos = pos(lag_f, lag_v, lag_h);
      if (locked && lk_pos < 0) lk_pos = pos(lag_f, lag_v, lag_h);
      if (locked && trk_ok) begin
        total++;
        if (hcount !== 10'(lag_h) || vcount !== 10'(lag_v) ||
            visible !== (lag_h < HV && lag_v < VV) || writable !== (lag_v >= VV) ||
            frame_start !== (lag_h == 0 && lag_v == 0)) begin
          bad++; trk_ok = 0;
          $display("FAIL clean_track: got hc=%0d vc=%0d vis=%b wr=%b fs=%b expected hc=%0d vc=%0d vis=%b wr=%b fs=%b",
            hcount, vcount, visible, writable, frame_start, lag_h, lag_v,
            (lag_h < HV && lag_v < VV), (lag_v >= VV), (lag_h == 0 && lag_v == 0));
        end
      end
    end
    total++;
    if (hl_pos < LL * H || hl_pos >= (LL + 1) * H) begin
      bad++; $display("FAIL clean_h_lock_time: got pos %0d expected in [%0d,%0d)", hl_pos, LL * H, (LL + 1) * H);
    end
    total++;
    if (lk_pos != pos(1, VSS, 0)) begin
      bad++; $display("FAIL clean_lock_time: got pos %0d expected %0d", lk_pos, pos(1, VSS, 0));
    end
    total++;
    if (n_herr != herr0 || n_verr != verr0) begin
      bad++; $display("FAIL clean_no_err: got h_err=%0d v_err=%0d expected 0 0", n_herr - herr0, n_verr - verr0);
    end
  endtask

  task automatic test_h_violation(input int k);
    int l, f0, herr0, verr0, e_pos, hl_pos, lk_pos, x_e, x_hl, x_lk;
    bit e_hl, e_lk;
    string nm;
    l = $urandom_range(VSS - 6, 1);
    f0 = src_f + 1;
    kind = k; pert_f = f0; pert_l = l;
    herr0 = n_herr; verr0 = n_verr;
    e_pos = -1; hl_pos = -1; lk_pos = -1; e_hl = 1; e_lk = 1;
    case (k)
      1:       begin nm = "short_line"; x_e = pos(f0, l + 1, HSS); x_hl = pos(f0, l + 5, HSS); end
      2:       begin nm = "no_hpulse";  x_e = pos(f0, l, HSS);     x_hl = pos(f0, l + 4, HSS); end
      default: begin nm = "narrow_hs";  x_e = pos(f0, l, HSE - 1); x_hl = pos(f0, l + 4, HSS); end
    endcase
    x_lk = pos(f0 + 1, VSS, 0);
    for (int i = 0; i < 5 * V * H && lk_pos < 0; i++) begin
      tick();
      if (h_err && e_pos < 0) begin e_pos = pos(lag_f, lag_v, lag_h); e_hl = h_locked; e_lk = locked; end
      if (e_pos >= 0 && h_locked && hl_pos < 0) hl_pos = pos(lag_f, lag_v, lag_h);
      if (e_pos >= 0 && locked && lk_pos < 0) lk_pos = pos(lag_f, lag_v, lag_h);
    end
    total++;
    if (e_pos != x_e) begin bad++; $display("FAIL %s_err_pos: got %0d expected %0d", nm, e_pos, x_e); end
    total++;
    if ({e_hl, e_lk} !== 2'b00) begin bad++; $display("FAIL %s_unlocked: got h_locked/locked=%b expected 00", nm, {e_hl, e_lk}); end
    total++;
    if (n_herr - herr0 != 1 || n_verr != verr0) begin
      bad++; $display("FAIL %s_err_count: got h=%0d v=%0d expected h=1 v=0", nm, n_herr - herr0, n_verr - verr0);
    end
    total++;
    if (hl_pos != x_hl) begin bad++; $display("FAIL %s_h_relock: got %0d expected %0d", nm, hl_pos, x_hl); end
    total++;
    if (lk_pos != x_lk) begin bad++; $display("FAIL %s_relock: got %0d expected %0d", nm, lk_pos, x_lk); end
    total++;
    if (hcount !== 10'(lag_h) || vcount !== 10'(lag_v)) begin
      bad++; $display("FAIL %s_counters: got %0d/%0d expected %0d/%0d", nm, hcount, vcount, lag_h, lag_v);
    end
    kind = 0;
  endtask

  task automatic test_vsync_shift();
    int f0, herr0, verr0, e_pos, lk_pos, hl_drops, rs_vc;
    bit e_hl, e_lk;
    f0 = src_f + 1;
    kind = 4; pert_f = f0; pert_l = -1;
    herr0 = n_herr; verr0 = n_verr;
    e_pos = -1; lk_pos = -1; hl_drops = 0; rs_vc = -1; e_hl = 0; e_lk = 1;
    for (int i = 0; i < 5 * V * H && lk_pos < 0; i++) begin
      tick();
      if (v_err && e_pos < 0) begin e_pos = pos(lag_f, lag_v, lag_h); e_hl = h_locked; e_lk = locked; end
      if (e_pos >= 0) begin
        if (!h_locked) hl_drops++;
        if (lag_f == f0 && lag_v == VSS + 1 && lag_h == 0) rs_vc = int'(vcount);
        if (locked && lk_pos < 0) lk_pos = pos(lag_f, lag_v, lag_h);
      end
    end
    total++;
    if (e_pos != pos(f0, VSS, 0)) begin bad++; $display("FAIL vshift_err_pos: got %0d expected %0d", e_pos, pos(f0, VSS, 0)); end
    total++;
    if ({e_hl, e_lk} !== 2'b10) begin bad++; $display("FAIL vshift_state: got h_locked/locked=%b expected 10", {e_hl, e_lk}); end
    total++;
    if (rs_vc != VSS) begin bad++; $display("FAIL vshift_resync: got vcount %0d expected %0d", rs_vc, VSS); end
    total++;
    if (hl_drops != 0) begin bad++; $display("FAIL vshift_h_locked_held: got %0d drop cycles expected 0", hl_drops); end
    total++;
    if (n_verr - verr0 != 1 || n_herr != herr0) begin
      bad++; $display("FAIL vshift_err_count: got v=%0d h=%0d expected v=1 h=0", n_verr - verr0, n_herr - herr0);
    end
    total++;
    if (lk_pos <= pos(f0, VSS + 1, 0) || lk_pos > pos(f0 + 2, VSS, 0)) begin
      bad++; $display("FAIL vshift_relock: got %0d expected in (%0d,%0d]", lk_pos, pos(f0, VSS + 1, 0), pos(f0 + 2, VSS, 0));
    end
    total++;
    if (hcount !== 10'(lag_h) || vcount !== 10'(lag_v)) begin
      bad++; $display("FAIL vshift_counters: got %0d/%0d expected %0d/%0d", hcount, vcount, lag_h, lag_v);
    end
    kind = 0;
  endtask

  task automatic test_rst_mid();
    int f0, herr0, verr0, hl_pos, lk_pos;
    hl_pos = -1; lk_pos = -1;
    for (int i = 0; i < V * H + 2 && !(src_h == H - 1 && src_v == V - 1); i++) tick();
    herr0 = n_herr; verr0 = n_verr;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (hcount !== 10'd0 || vcount !== 10'd0 ||
        {h_locked, locked, visible, writable, frame_start, h_err, v_err} !== 7'd0) begin
      bad++; $display("FAIL rst_mid_outputs: got hc=%0d vc=%0d flags=%b expected 0 0 0000000", hcount, vcount,
        {h_locked, locked, visible, writable, frame_start, h_err, v_err});
    end
    f0 = src_f;
    for (int i = 0; i < 3 * V * H && lk_pos < 0; i++) begin
      tick();
      if (h_locked && hl_pos < 0) hl_pos = pos(lag_f, lag_v, lag_h);
      if (locked && lk_pos < 0) lk_pos = pos(lag_f, lag_v, lag_h);
    end
    total++;
    if (hl_pos < pos(f0, LL, 0) || hl_pos >= pos(f0, LL + 1, 0)) begin
      bad++; $display("FAIL rst_mid_h_lock: got %0d expected in [%0d,%0d)", hl_pos, pos(f0, LL, 0), pos(f0, LL + 1, 0));
    end
    total++;
    if (lk_pos != pos(f0 + 1, VSS, 0)) begin
      bad++; $display("FAIL rst_mid_lock: got %0d expected %0d", lk_pos, pos(f0 + 1, VSS, 0));
    end
    total++;
    if (n_herr != herr0 || n_verr != verr0) begin
      bad++; $display("FAIL rst_mid_no_err: got h=%0d v=%0d expected 0 0", n_herr - herr0, n_verr - verr0);
    end
  endtask

  initial begin
    rst = 1'b1; hsync = 1'b1; vsync = 1'b1;
    test_reset();
    test_clean_lock();
    test_h_violation(1);
    test_h_violation(2);
    test_h_violation(3);
    test_vsync_shift();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
